// File: rtl/barrett_pkg.sv
// Shared constants and elaboration helpers for the Barrett modular reducers.
// The optional operand-range flag is enabled with BARRETT_RANGE_CHECK_EN.
package barrett_pkg;

  localparam int unsigned BARRETT_LATENCY = 4;

  // floor(2^(2*width) / q); only meaningful for width <= 31.
  function automatic longint unsigned barrett_mu(input int unsigned width,
                                                 input longint unsigned q);
    longint unsigned num;
    num = 64'd1 << (2 * width);
    return num / q;
  endfunction

  // Barrett error bound of at most two corrections needs 2^(width-1) < q < 2^width.
  function automatic bit barrett_q_ok(input int unsigned width, input longint unsigned q);
    longint unsigned lo;
    longint unsigned hi;
    lo = 64'd1 << (width - 1);
    hi = 64'd1 << width;
    return (q > lo) && (q < hi);
  endfunction

endpackage

// File: rtl/barrett_final_sub.sv
// Final correction of a Barrett/Montgomery style reducer: maps r in [0, 3Q) onto [0, Q)
// with at most one of two conditional subtractions.
module barrett_final_sub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned Q     = 251
) (
  input  logic [WIDTH+1:0] r_i,
  output logic [WIDTH-1:0] res_o
);

  localparam logic [WIDTH+1:0] Q1 = (WIDTH + 2)'(Q);
  localparam logic [WIDTH+1:0] Q2 = (WIDTH + 2)'(2 * Q);

  logic [WIDTH+1:0] sub;

  always_comb begin
    sub = r_i;
    if (r_i >= Q2) begin
      sub = r_i - Q2;
    end else if (r_i >= Q1) begin
      sub = r_i - Q1;
    end
    res_o = WIDTH'(sub);
  end

endmodule

// File: rtl/barrett_mod_mul.sv
// Four-stage pipelined (a*b) mod Q via Barrett reduction with a global valid/ready stall.
// Define BARRETT_RANGE_CHECK_EN to add the out_err operand-range flag.
module barrett_mod_mul
  import barrett_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned Q     = 251
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef BARRETT_RANGE_CHECK_EN
  ,
  output logic             out_err
`endif
);

  localparam longint unsigned MuFull = barrett_mu(WIDTH, Q);
  localparam logic [WIDTH:0]   Mu    = (WIDTH + 1)'(MuFull);
  localparam logic [WIDTH+1:0] QExt  = (WIDTH + 2)'(Q);

  if (!barrett_q_ok(WIDTH, Q)) begin : g_bad_q
    $fatal(1, "barrett_mod_mul: Q must satisfy 2^(WIDTH-1) < Q < 2^WIDTH");
  end

  logic advance;

  // Stage valids; bubbles flow through untouched.
  logic v1_q, v2_q, v3_q, out_valid_q;

  logic [2*WIDTH-1:0] p1_q, p1_d;
  logic [WIDTH+1:0]   p2_q, p2_d;
  logic [WIDTH:0]     t2_q, t2_d;
  logic [WIDTH+1:0]   r3_q, r3_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [3*WIDTH:0]   prod_mu;
  logic [WIDTH+1:0]   tq;

  assign advance  = ~out_valid_q | out_ready;
  assign in_ready = advance;

  always_comb begin
    p1_d    = (2 * WIDTH)'(in_a) * (2 * WIDTH)'(in_b);
    prod_mu = (3 * WIDTH + 1)'(p1_q) * (3 * WIDTH + 1)'(Mu);
    t2_d    = (WIDTH + 1)'(prod_mu >> (2 * WIDTH));
    // Only the low WIDTH+2 bits of p matter: r = p - t*Q is known to lie in [0, 3Q).
    p2_d    = (WIDTH + 2)'(p1_q);
    tq      = (WIDTH + 2)'(t2_q) * QExt;
    r3_d    = p2_q - tq;
  end

  barrett_final_sub #(
    .WIDTH (WIDTH),
    .Q     (Q)
  ) u_final_sub (
    .r_i   (r3_q),
    .res_o (data_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      out_valid_q <= 1'b0;
      p1_q        <= '0;
      p2_q        <= '0;
      t2_q        <= '0;
      r3_q        <= '0;
      data_q      <= '0;
    end else if (advance) begin
      v1_q        <= in_valid;
      v2_q        <= v1_q;
      v3_q        <= v2_q;
      out_valid_q <= v3_q;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      t2_q        <= t2_d;
      r3_q        <= r3_d;
      data_q      <= data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = data_q;

`ifdef BARRETT_RANGE_CHECK_EN
  localparam logic [WIDTH-1:0] QOp = WIDTH'(Q);

  logic e1_q, e2_q, e3_q, err_q;
  logic e1_d;

  // Flag is raised from the raw operands; the product is still reduced as-is.
  assign e1_d = (in_a >= QOp) | (in_b >= QOp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e1_q  <= 1'b0;
      e2_q  <= 1'b0;
      e3_q  <= 1'b0;
      err_q <= 1'b0;
    end else if (advance) begin
      e1_q  <= e1_d;
      e2_q  <= e1_q;
      e3_q  <= e2_q;
      err_q <= e3_q;
    end
  end

  assign out_err = err_q;
`endif

endmodule

// File: tb/tb_barrett_mod_mul.sv
// Scoreboard bench for barrett_mod_mul (Q=251): directed vectors, random stream with
// random back-pressure, stall freeze and asynchronous reset flush.
module tb_barrett_mod_mul;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
`ifdef BARRETT_RANGE_CHECK_EN
  logic       out_err;
`endif

  barrett_mod_mul #(
    .WIDTH (8),
    .Q     (251)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef BARRETT_RANGE_CHECK_EN
    ,
    .out_err   (out_err)
`endif
  );

  typedef struct {
    logic [7:0] d;
    logic       e;
    int         acc;
    bit         lat;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   pushes = 0;
  int   pops = 0;
  bit   rmode = 0;
  logic ready_force = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Sole driver of out_ready; updated 2ns after each rising edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rmode ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: a transfer happens at the next rising edge when valid & ready at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got data %0d, required no output", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", int'(out_data), int'(e.d));
`ifdef BARRETT_RANGE_CHECK_EN
          chk("out_err", int'(out_err), int'(e.e));
`endif
          if (e.lat) chk("latency", cyc - e.acc, 4);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] d,
                      input logic e, input bit lat);
    int n;
    exp_t x;
    n = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("accept_timeout", int'(in_ready), 1);
    if (in_ready) begin
      x.d = d;
      x.e = e;
      x.acc = cyc;
      x.lat = lat;
      exp_q.push_back(x);
      pushes++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk(name, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  logic [7:0] sa[6] = '{8'd3, 8'd7, 8'd16, 8'd20, 8'd11, 8'd12};
  logic [7:0] sb[6] = '{8'd5, 8'd9, 8'd16, 8'd13, 8'd11, 8'd21};
  logic [7:0] se[6] = '{8'd15, 8'd63, 8'd5, 8'd9, 8'd121, 8'd1};

  initial begin
    int idx;
    int n;
    int pops_snap;
    logic [7:0] ra;
    logic [7:0] rb;
    exp_t x;

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    #23;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
`ifdef BARRETT_RANGE_CHECK_EN
    chk("rst_out_err", int'(out_err), 0);
`endif

    // Back-to-back directed vectors with full throughput and 4-cycle latency.
    send(8'd2, 8'd1, 8'd2, 1'b0, 1'b1);
    send(8'd1, 8'd1, 8'd1, 1'b0, 1'b1);
    send(8'd21, 8'd11, 8'd231, 1'b0, 1'b1);
    send(8'd210, 8'd110, 8'd8, 1'b0, 1'b1);
    send(8'd250, 8'd250, 8'd1, 1'b0, 1'b1);
    send(8'd0, 8'd200, 8'd0, 1'b0, 1'b1);
    send(8'd250, 8'd1, 8'd250, 1'b0, 1'b1);
    send(8'd128, 8'd2, 8'd5, 1'b0, 1'b1);
    send(8'd200, 8'd200, 8'd91, 1'b0, 1'b1);
    send(8'd100, 8'd3, 8'd49, 1'b0, 1'b1);
    wait_drain("drain_directed");

    // Freeze: with out_ready low exactly four operands fit before in_ready drops.
    ready_force = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idx = 0;
    in_a = sa[0];
    in_b = sb[0];
    in_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (in_ready && idx < 6) begin
        x.d = se[idx];
        x.e = 1'b0;
        x.acc = cyc;
        x.lat = 1'b0;
        exp_q.push_back(x);
        pushes++;
        idx++;
      end
      if (c == 6) chk("stall_data_early", int'(out_data), 15);
      @(posedge clk);
      #1;
      if (idx < 6) begin
        in_a = sa[idx];
        in_b = sb[idx];
      end
    end
    @(negedge clk);
    chk("stall_accepts", idx, 4);
    chk("stall_in_ready", int'(in_ready), 0);
    chk("stall_out_valid", int'(out_valid), 1);
    chk("stall_data_late", int'(out_data), 15);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ready_force = 1'b1;
    wait_drain("drain_stall");
    send(sa[4], sb[4], se[4], 1'b0, 1'b0);
    send(sa[5], sb[5], se[5], 1'b0, 1'b0);
    wait_drain("drain_stall_tail");

    // Random stream under random back-pressure.
    rmode = 1'b1;
    for (int i = 0; i < 100; i++) begin
      ra = 8'($urandom_range(0, 250));
      rb = 8'($urandom_range(0, 250));
      send(ra, rb, 8'((int'(ra) * int'(rb)) % 251), 1'b0, 1'b0);
    end
    wait_drain("drain_random");
    rmode = 1'b0;
    ready_force = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("push_pop_balance", pops, pushes);

    // Asynchronous reset with three items in flight, first one already presented.
    ready_force = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send(8'd3, 8'd5, 8'd15, 1'b0, 1'b0);
    send(8'd7, 8'd9, 8'd63, 1'b0, 1'b0);
    send(8'd16, 8'd16, 8'd5, 1'b0, 1'b0);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("prereset_out_valid", int'(out_valid), 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(out_valid), 0);
    chk("async_rst_data", int'(out_data), 0);
    exp_q.delete();
    pops_snap = pops;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_force = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_rst_no_stale", pops - pops_snap, 0);
    chk("post_rst_out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    send(8'd21, 8'd11, 8'd231, 1'b0, 1'b1);
    wait_drain("drain_post_reset");

`ifdef BARRETT_RANGE_CHECK_EN
    send(8'd251, 8'd1, 8'd0, 1'b1, 1'b0);
    send(8'd250, 8'd1, 8'd250, 1'b0, 1'b0);
    wait_drain("drain_range");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
